// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between two masters.
// Latency: request in IDLE -> RAM access next cycle -> ready pulse the cycle after; requesters hold until ready.
module mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req0_cmd,
  input  logic [ADDR_W:0]   req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [1:0]        req1_cmd,
  input  logic [ADDR_W:0]   req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              ready0,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b01;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;   // 1 = port 1 was served last

  logic req0, req1, win;

  assign req0 = (req0_cmd == CMD_READ) || (req0_cmd == CMD_WRITE);
  assign req1 = (req1_cmd == CMD_READ) || (req1_cmd == CMD_WRITE);
  // On contention the port not served last wins; otherwise the lone requester.
  assign win  = (req0 && req1) ? ~last_q : ~req0;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          cmd_d   = win ? req1_cmd   : req0_cmd;
          addr_d  = win ? req1_addr  : req0_addr;
          wdata_d = win ? req1_wdata : req0_wdata;
          gnt_d   = win ? 2'b10 : 2'b01;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them asynchronously.
  assign gnt       = gnt_q;
  assign ram_addr  = addr_q[ADDR_W-1:0];
  assign ram_din   = wdata_q;
  assign ram_write = (state_q == ACCESS) && (cmd_q == CMD_WRITE) && !addr_q[ADDR_W];
  assign ready0    = (state_q == DONE) && gnt_q[0];
  assign ready1    = (state_q == DONE) && gnt_q[1];
  assign rdata     = ((state_q == DONE) && (cmd_q == CMD_READ) && !addr_q[ADDR_W])
                     ? ram_dout : '0;

endmodule
